// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
// Both ends import these defaults so the link agrees on framing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter shared by the UART transmitter and receiver.
// bit_end marks the last cycle of each CLKS_PER_BIT-long bit.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  assign bit_end = enable && (cnt_q == LAST);

  // count 0..LAST, restarting on every bit boundary or clear
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8-N-1 serial transmitter with a valid/ready byte input.
// Line idles high; start low, data LSB first, stop high.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int IW =
    (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  uart_state_t state_q;
  uart_state_t state_d;

  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [IW-1:0]        idx_q;
  logic [IW-1:0]        idx_d;
  logic                 tx_q;
  logic                 tx_d;
  logic                 done_q;
  logic                 done_d;
  logic                 accept;
  logic                 run;
  logic                 bit_end;

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign accept   = tx_valid && tx_ready;
  assign run      = (state_q != IDLE);
  assign tx_out   = tx_q;
  assign tx_done  = done_q;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (run),
    .bit_end(bit_end)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: advance one frame field per completed bit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && idx_q == LAST_IDX)
               state_d = STOP;
      STOP:  if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath next values: capture on accept, shift per data bit
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    unique case (1'b1)
      accept: begin
        shift_d = tx_data;
        idx_d   = '0;
      end
      (state_q == START && bit_end): begin
        idx_d = '0;
      end
      (state_q == DATA && bit_end): begin
        shift_d = shift_q >> 1;
        idx_d   = idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  // outputs, computed from the upcoming state so they land in a flop
  always_comb begin
    tx_d   = 1'b1;
    done_d = (state_q == STOP) && bit_end;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // datapath and registered line/pulse outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule
